dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 65 ++++++
 tb/tb_dff_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - valid-tagged register pipeline with occupancy count
// Optional per-stage tap read port is added when DFF_PIPE_TAP_EN is defined.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
`ifdef DFF_PIPE_TAP_EN
  input  logic [SW-1:0]    TAP_SEL,
  output logic [WIDTH-1:0] TAP,
  output logic             TAP_VLD,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD,
  output logic [CW-1:0]    COUNT
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;

  // Count tracks entries in minus entries out, so it always equals popcount(vld).
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) data[k] <= '0;
      vld   <= '0;
      COUNT <= '0;
    end else if (FLUSH) begin
      vld   <= '0;
      COUNT <= '0;
    end else if (EN) begin
      data[0] <= D;
      vld[0]  <= D_VLD;
      for (int k = 1; k < DEPTH; k++) begin
        data[k] <= data[k-1];
        vld[k]  <= vld[k-1];
      end
      COUNT <= COUNT + CW'(D_VLD) - CW'(vld[DEPTH-1]);
    end
  end

  assign Q     = data[DEPTH-1];
  assign Q_VLD = vld[DEPTH-1];

`ifdef DFF_PIPE_TAP_EN
  // Selects past the last stage match no iteration and read back as zero.
  always_comb begin
    TAP     = '0;
    TAP_VLD = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (TAP_SEL == SW'(k)) begin
        TAP     = data[k];
        TAP_VLD = vld[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - randomized self-checking bench for dff_pipe (DEPTH 4 and DEPTH 1)
// Tap checks are compiled in when DFF_PIPE_TAP_EN is defined.
module tb_dff_pipe;

  logic       CK = 1'b0;
  logic       RST_N, EN, FLUSH, D_VLD;
  logic [7:0] D;

  logic [7:0] q4, q1;
  logic       qv4, qv1;
  logic [2:0] cnt4;
  logic [0:0] cnt1;
`ifdef DFF_PIPE_TAP_EN
  logic [1:0] tap_sel4;
  logic [0:0] tap_sel1;
  logic [7:0] tap4, tap1;
  logic       tapv4, tapv1;
`endif

  dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .CK(CK), .RST_N(RST_N), .EN(EN), .FLUSH(FLUSH), .D(D), .D_VLD(D_VLD),
`ifdef DFF_PIPE_TAP_EN
    .TAP_SEL(tap_sel4), .TAP(tap4), .TAP_VLD(tapv4),
`endif
    .Q(q4), .Q_VLD(qv4), .COUNT(cnt4)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .CK(CK), .RST_N(RST_N), .EN(EN), .FLUSH(FLUSH), .D(D), .D_VLD(D_VLD),
`ifdef DFF_PIPE_TAP_EN
    .TAP_SEL(tap_sel1), .TAP(tap1), .TAP_VLD(tapv1),
`endif
    .Q(q1), .Q_VLD(qv1), .COUNT(cnt1)
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } ent_t;

  // History of the last four accepted inputs, newest at the back.
  ent_t hist[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t stage(input int k);
    return hist[hist.size() - 1 - k];
  endfunction

  function automatic int occupancy(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (stage(k).v) c++;
    return c;
  endfunction

  task automatic model_edge();
    if (!RST_N) begin
      hist.delete();
      for (int k = 0; k < 4; k++) hist.push_back('0);
    end else if (FLUSH) begin
      for (int k = 0; k < 4; k++) hist[k].v = 1'b0;
    end else if (EN) begin
      hist.push_back('{d: D, v: D_VLD});
      void'(hist.pop_front());
    end
  endtask

  task automatic check_all();
    check("q4",    32'(q4),   32'(stage(3).d));
    check("qv4",   32'(qv4),  32'(stage(3).v));
    check("cnt4",  32'(cnt4), 32'(occupancy(4)));
    check("q1",    32'(q1),   32'(stage(0).d));
    check("qv1",   32'(qv1),  32'(stage(0).v));
    check("cnt1",  32'(cnt1), 32'(occupancy(1)));
`ifdef DFF_PIPE_TAP_EN
    check("tap4",  32'(tap4),  32'(stage(int'(tap_sel4)).d));
    check("tapv4", 32'(tapv4), 32'(stage(int'(tap_sel4)).v));
    check("tap1",  32'(tap1),  (tap_sel1 != 0) ? 32'(0) : 32'(stage(0).d));
    check("tapv1", 32'(tapv1), (tap_sel1 != 0) ? 32'(0) : 32'(stage(0).v));
`endif
  endtask

  task automatic cyc(input logic rst, input logic en, input logic fl,
                     input logic [7:0] d, input logic dv);
    RST_N = rst; EN = en; FLUSH = fl; D = d; D_VLD = dv;
`ifdef DFF_PIPE_TAP_EN
    tap_sel4 = 2'($urandom_range(0, 3));
    tap_sel1 = 1'($urandom_range(0, 1));
`endif
    @(posedge CK);
    model_edge();
    #1;
    check_all();
  endtask

  logic [7:0] q_hold;

  initial begin
    for (int k = 0; k < 4; k++) hist.push_back('0);
    RST_N = 1'b0; EN = 1'b0; FLUSH = 1'b0; D = '0; D_VLD = 1'b0;
`ifdef DFF_PIPE_TAP_EN
    tap_sel4 = '0;
    tap_sel1 = '0;
`endif
    cyc(0, 1, 1, 8'h33, 1);
    cyc(0, 0, 0, 8'h44, 1);
    check("rst_q", 32'(q4), 32'h0);
    check("rst_cnt", 32'(cnt4), 32'h0);

    // Fill with 1..6
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1, 0, 8'(i), 1);
      check("fill_cnt", 32'(cnt4), 32'((i < 4) ? i : 4));
      if (i >= 4) check("fill_q", 32'(q4), 32'(i - 3));
    end

    // Hold five cycles, then drain
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 8'hEE, 1);
      check("hold_q", 32'(q4), 32'h3);
      check("hold_cnt", 32'(cnt4), 32'h4);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 8'h00, 0);
      check("drain_cnt", 32'(cnt4), 32'(3 - i));
      check("drain_qv", 32'(qv4), (i < 3) ? 32'h1 : 32'h0);
    end

    // Flush with three entries inside, colliding with EN and D_VLD
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'(8'h10 + i), 1);
    check("pre_flush_cnt", 32'(cnt4), 32'h3);
    q_hold = q4;
    cyc(1, 1, 1, 8'h77, 1);
    check("flush_cnt", 32'(cnt4), 32'h0);
    check("flush_qv", 32'(qv4), 32'h0);
    check("flush_q", 32'(q4), 32'(q_hold));

    // Mid-stream reset, including a reset pulse between edges
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 8'(8'h20 + i), 1);
    q_hold = q4;
    RST_N = 1'b0;
    #2;
    check("async_q", 32'(q4), 32'(q_hold));
    check("async_cnt", 32'(cnt4), 32'h4);
    RST_N = 1'b1;
    cyc(0, 1, 0, 8'hFF, 1);
    check("mid_rst_q", 32'(q4), 32'h0);
    check("mid_rst_cnt", 32'(cnt4), 32'h0);
    cyc(1, 1, 0, 8'hAA, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'h00, 0);
    check("post_rst_q", 32'(q4), 32'hAA);
    check("post_rst_qv", 32'(qv4), 32'h1);

    // DEPTH=1 behaves as a plain enabled flop
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 8'(i % 2), 1);
      check("dff1_q", 32'(q1), 32'(i % 2));
    end

`ifdef DFF_PIPE_TAP_EN
    cyc(0, 0, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h5A, 1);
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h00, 0);
    tap_sel4 = 2'd2;
    #1;
    check("tap_s2", 32'(tap4), 32'h5A);
    check("tap_s2_v", 32'(tapv4), 32'h1);
    tap_sel4 = 2'd3;
    #1;
    check("tap_s3_v", 32'(tapv4), 32'h0);
    tap_sel1 = 1'b1;
    #1;
    check("tap_oob", 32'({tap1, tapv1}), 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 19) == 0), 8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
